// File: rtl/fc1_seq_ctrl.sv
// Sequencer for the fc1 layer: streams NUM_INPUTS activations into the MAC array, one
// registered beat per accept, then holds a result-valid handshake until downstream takes it.
module fc1_seq_ctrl #(
   parameter int unsigned NUM_INPUTS = 784,
   parameter int unsigned ADDR_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
   parameter int unsigned ACT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   input  logic                  in_valid,
   input  logic [ACT_WIDTH-1:0]  in_data,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic                  mac_en,
   output logic [ACT_WIDTH-1:0]  mac_act,
   output logic                  mac_last,
   output logic                  mac_clear,
   output logic                  out_valid,
   input  logic                  out_ready
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_INPUTS - 1);

   state_t                r_state;
   state_t                w_state_d;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] r_rom_addr;
   logic [ACT_WIDTH-1:0]  r_mac_act;
   logic                  r_mac_en;
   logic                  r_mac_last;
   logic                  r_mac_clear;
   logic                  w_accept;
   logic                  w_cnt_last;
   logic                  w_launch;

   always_comb begin
      w_accept   = in_valid & (r_state == StRun);
      w_cnt_last = (r_cnt == LAST_IDX);
      w_launch   = (r_state == StIdle) & start;
      w_state_d  = r_state;
      case (r_state)
         StIdle:  if (start) w_state_d = StRun;
         StRun:   if (w_accept && w_cnt_last) w_state_d = StDrain;
         // The final MAC beat is on the bus during this single cycle.
         StDrain: w_state_d = StDone;
         StDone:  if (out_ready) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_rom_addr  <= '0;
         r_mac_act   <= '0;
         r_mac_en    <= 1'b0;
         r_mac_last  <= 1'b0;
         r_mac_clear <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_mac_clear <= w_launch;
         r_mac_en    <= w_accept;
         r_mac_last  <= w_accept & w_cnt_last;
         if (w_launch) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_rom_addr <= r_cnt;
            r_mac_act  <= in_data;
            // Counter parks on the last index so it never wraps.
            if (!w_cnt_last) r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign busy      = (r_state != StIdle);
   assign in_ready  = (r_state == StRun);
   assign out_valid = (r_state == StDone);
   assign rom_addr  = r_rom_addr;
   assign mac_act   = r_mac_act;
   assign mac_en    = r_mac_en;
   assign mac_last  = r_mac_last;
   assign mac_clear = r_mac_clear;

endmodule

// File: tb/tb_fc1_seq_ctrl.sv
// Directed bench for fc1_seq_ctrl: a 4-input instance for the handshake scenarios and a
// default 784-input instance for the full-length run.
module tb_fc1_seq_ctrl;

   logic       clk;
   logic       rst;
   // 4-input instance
   logic       start, in_valid, out_ready;
   logic [7:0] in_data;
   logic       busy, in_ready, mac_en, mac_last, mac_clear, out_valid;
   logic [1:0] rom_addr;
   logic [7:0] mac_act;
   // 784-input instance
   logic       b_start, b_in_valid, b_out_ready;
   logic [7:0] b_in_data;
   logic       b_busy, b_in_ready, b_mac_en, b_mac_last, b_mac_clear, b_out_valid;
   logic [9:0] b_rom_addr;
   logic [7:0] b_mac_act;

   int n_chk  = 0;
   int n_pass = 0;
   int en_cnt = 0, clr_cnt = 0, ben_cnt = 0, overlap = 0;

   fc1_seq_ctrl #(.NUM_INPUTS(4), .ADDR_WIDTH(2), .ACT_WIDTH(8)) dut4 (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .rom_addr(rom_addr), .mac_en(mac_en), .mac_act(mac_act), .mac_last(mac_last),
      .mac_clear(mac_clear), .out_valid(out_valid), .out_ready(out_ready)
   );

   fc1_seq_ctrl dut784 (
      .clk(clk), .rst(rst), .start(b_start), .busy(b_busy),
      .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .rom_addr(b_rom_addr), .mac_en(b_mac_en), .mac_act(b_mac_act), .mac_last(b_mac_last),
      .mac_clear(b_mac_clear), .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mac_en) en_cnt++;
      if (mac_clear) clr_cnt++;
      if (mac_en && mac_clear) overlap++;
      if (b_mac_en) ben_cnt++;
      if (b_mac_en && b_mac_clear) overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_in_ready"}, 32'(in_ready), 0);
      chk({tag, "_mac_en"}, 32'(mac_en), 0);
      chk({tag, "_mac_last"}, 32'(mac_last), 0);
      chk({tag, "_mac_clear"}, 32'(mac_clear), 0);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
      chk({tag, "_mac_act"}, 32'(mac_act), 0);
   endtask

   int pat [7] = '{1, 0, 0, 1, 1, 0, 1};

   initial begin
      int clr0, en0, ben0, exp_idx;
      logic [1:0] last_addr;
      logic [7:0] last_act, d;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      tick(); tick();
      chk_all_zero("reset");
      chk("reset_big_busy", 32'(b_busy), 0);
      rst = 1'b0;
      tick();

      // Back-to-back stream of four beats
      clr0 = clr_cnt; en0 = en_cnt;
      start = 1'b1; tick(); start = 1'b0;
      chk("s1_clear", 32'(mac_clear), 1);
      chk("s1_busy", 32'(busy), 1);
      chk("s1_ready", 32'(in_ready), 1);
      chk("s1_en0", 32'(mac_en), 0);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = 8'(8'h11 * (i + 1));
         in_data = d;
         tick();
         chk("s1_en", 32'(mac_en), 1);
         chk("s1_addr", 32'(rom_addr), 32'(i));
         chk("s1_act", 32'(mac_act), 32'(d));
         chk("s1_last", 32'(mac_last), (i == 3) ? 1 : 0);
         chk("s1_clr_off", 32'(mac_clear), 0);
      end
      chk("s1_drain_ready", 32'(in_ready), 0);
      chk("s1_drain_busy", 32'(busy), 1);
      chk("s1_drain_ov", 32'(out_valid), 0);
      tick();
      in_valid = 1'b0;
      chk("s1_done_ov", 32'(out_valid), 1);
      chk("s1_done_en", 32'(mac_en), 0);
      chk("s1_done_last", 32'(mac_last), 0);

      // Downstream back-pressure, then ready together with a stray start
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_ov", 32'(out_valid), 1);
         chk("hold_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1; start = 1'b1;
      tick();
      out_ready = 1'b0; start = 1'b0;
      chk("hs_busy", 32'(busy), 0);
      chk("hs_ov", 32'(out_valid), 0);
      tick();
      chk("hs_no_clear", 32'(mac_clear), 0);
      chk("hs_idle", 32'(busy), 0);
      chk("s1_clr_count", 32'(clr_cnt - clr0), 1);
      chk("s1_en_count", 32'(en_cnt - en0), 4);

      // Bubbly input stream
      en0 = en_cnt;
      start = 1'b1; tick(); start = 1'b0;
      chk("s2_clear", 32'(mac_clear), 1);
      exp_idx = 0; last_addr = 2'd3; last_act = 8'h44;
      for (int j = 0; j < 7; j++) begin
         in_valid = (pat[j] != 0);
         d = 8'(8'hA0 + j);
         in_data = d;
         tick();
         if (pat[j] != 0) begin
            last_addr = 2'(exp_idx);
            last_act = d;
            exp_idx++;
         end
         chk("s2_en", 32'(mac_en), 32'(pat[j]));
         chk("s2_addr", 32'(rom_addr), 32'(last_addr));
         chk("s2_act", 32'(mac_act), 32'(last_act));
      end
      in_valid = 1'b0;
      tick();
      chk("s2_done_ov", 32'(out_valid), 1);
      chk("s2_en_count", 32'(en_cnt - en0), 4);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("s2_idle", 32'(busy), 0);

      // Stray start during RUN, then reset after two accepts
      start = 1'b1; tick();
      in_valid = 1'b1; in_data = 8'h55;
      tick();
      start = 1'b0;
      chk("s3_no_clear", 32'(mac_clear), 0);
      chk("s3_addr0", 32'(rom_addr), 0);
      chk("s3_act0", 32'(mac_act), 32'h55);
      in_data = 8'h66;
      tick();
      chk("s3_addr1", 32'(rom_addr), 1);
      rst = 1'b1; start = 1'b1; in_data = 8'h77;
      tick();
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      chk_all_zero("midrst");
      tick();
      chk("midrst_idle", 32'(busy), 0);
      chk("midrst_ov", 32'(out_valid), 0);
      clr0 = clr_cnt; en0 = en_cnt;
      start = 1'b1; tick(); start = 1'b0;
      chk("s3_clear", 32'(mac_clear), 1);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'(8'h70 + i);
         tick();
         chk("s3_addr", 32'(rom_addr), 32'(i));
         chk("s3_act", 32'(mac_act), 32'(8'h70 + i));
      end
      in_valid = 1'b0;
      tick();
      chk("s3_done_ov", 32'(out_valid), 1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("s3_clr_count", 32'(clr_cnt - clr0), 1);
      chk("s3_en_count", 32'(en_cnt - en0), 4);

      // Full-length 784-beat inference
      ben0 = ben_cnt;
      b_start = 1'b1; tick(); b_start = 1'b0;
      chk("big_clear", 32'(b_mac_clear), 1);
      b_in_valid = 1'b1;
      for (int i = 0; i < 784; i++) begin
         b_in_data = 8'(i);
         tick();
         if (i == 782) chk("big_last_early", 32'(b_mac_last), 0);
         if (i == 783) begin
            chk("big_addr_last", 32'(b_rom_addr), 783);
            chk("big_last", 32'(b_mac_last), 1);
            chk("big_act_last", 32'(b_mac_act), 32'h0F);
         end
      end
      b_in_valid = 1'b0;
      tick();
      chk("big_ov", 32'(b_out_valid), 1);
      chk("big_en_count", 32'(ben_cnt - ben0), 784);
      b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
      chk("big_idle", 32'(b_busy), 0);

      chk("clr_en_overlap", 32'(overlap), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fc1_seq_ctrl.md
FC1_SEQ_CTRL -- requirements
Module: fc1_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 784, meaning input features per inference (fc1 fan-in).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default $clog2(784) = 10, meaning the weight ROM address width.
REQ-003 The block SHALL have parameter ACT_WIDTH, default 8, meaning the activation width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 The block SHALL have port start, input, 1, a one-cycle request to begin an inference.
REQ-007 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 The block SHALL have ports in_valid (input, 1), in_data (input, ACT_WIDTH) and in_ready (output, 1), forming the activation stream, in feature order 0..NUM_INPUTS-1.
REQ-009 The block SHALL have port rom_addr, output, ADDR_WIDTH, the feature index driven to the combinational fc1 weight ROM.
REQ-010 The block SHALL have ports mac_en (output, 1), mac_act (output, ACT_WIDTH) and mac_last (output, 1), the MAC-array strobe, the activation, and the final-beat flag.
REQ-011 The block SHALL have port mac_clear, output, 1, a one-cycle pulse that zeroes the accumulators.
REQ-012 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake to the downstream layer.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, RUN, DRAIN and DONE.
REQ-014 In IDLE, start=1 SHALL cause mac_clear=1 on the next cycle, clear the feature counter cnt to 0, and move the FSM to RUN.
REQ-015 start SHALL be ignored in every state other than IDLE.
REQ-016 in_ready SHALL be 1 only in RUN; the combinational form (in_ready = state==RUN) is allowed.
REQ-017 An accept SHALL be defined as in_valid & in_ready.
REQ-018 On an accept with cnt=k, the next cycle SHALL show rom_addr=k, mac_act=in_data, mac_en=1 and mac_last=(k==NUM_INPUTS-1), and cnt SHALL become k+1; the latency from accept to mac_en is 1 cycle.
REQ-019 In any cycle with no accept, mac_en and mac_last SHALL be 0 on the next cycle, while rom_addr and mac_act hold their values; bubbles are allowed and nothing is dropped or duplicated.
REQ-020 An accept with cnt=NUM_INPUTS-1 SHALL move the FSM to DRAIN; cnt SHALL never exceed NUM_INPUTS-1 as an address, so there is no wrap-around.
REQ-021 DRAIN SHALL last exactly 1 cycle: it is the cycle in which the last mac_en/mac_last beat is presented; the FSM then moves to DONE.
REQ-022 In DONE, out_valid SHALL be 1 and held stable until out_ready=1; the FSM then returns to IDLE and out_valid is 0 on the following cycle.
REQ-023 out_ready SHALL be ignored whenever out_valid=0.
REQ-024 If out_ready=1 and start=1 arrive together in DONE, the block SHALL complete the handshake and ignore start; a new start is needed in IDLE.
REQ-025 mac_clear SHALL never coincide with mac_en.
REQ-026 mac_clear SHALL be asserted exactly once per inference.
REQ-027 Exactly NUM_INPUTS mac_en pulses SHALL occur between mac_clear and out_valid.
REQ-028 rom_addr SHALL be registered; the ROM weight word is valid in the same cycle as mac_en, and the MAC array consumes both together.
REQ-029 The cnt width SHALL be ADDR_WIDTH, and the last-index compare SHALL be done at full width.

Reset
REQ-030 rst=1 SHALL force state IDLE, cnt=0 and rom_addr=0 on the next edge.
REQ-031 rst=1 SHALL force mac_act=0, mac_en=0, mac_last=0, mac_clear=0, out_valid=0, busy=0 and in_ready=0 on the next edge.
REQ-032 rst SHALL take priority over start and over all handshakes.
REQ-033 A reset mid-RUN, DRAIN or DONE SHALL abandon the inference with no out_valid; partial accumulator contents are left for the next mac_clear.

Verification
REQ-034 Scenario, NUM_INPUTS=4: start, then in_valid held high with data 0x11,0x22,0x33,0x44 -> mac_clear at cycle 1; mac_en on 4 consecutive cycles with rom_addr 0..3 and mac_act 0x11..0x44; mac_last only with 0x44; 1 DRAIN cycle; then out_valid=1.
REQ-035 Scenario, NUM_INPUTS=4: in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 mac_en pulses with rom_addr 0,1,2,3 in order, and rom_addr/mac_act stable through the bubbles.
REQ-036 Scenario: out_ready held 0 for 5 cycles in DONE -> out_valid stays 1 and in_ready stays 0; pulsing out_ready returns busy to 0 on the next cycle.
REQ-037 Scenario: reset asserted after 2 of 4 accepts -> next cycle all outputs are 0 and state is IDLE; a fresh start replays from rom_addr 0 with one mac_clear.
REQ-038 Scenario: start pulsed during RUN and during DONE -> no second mac_clear, and cnt is unaffected.
REQ-039 Scenario, default NUM_INPUTS=784: 784 back-to-back beats -> the last beat shows rom_addr=783 and mac_last=1, with 784 total mac_en pulses.
